module_bus_controller: RTL and testbench
========================================

Name: module_bus_controller

Overview:
- Single-master transaction controller for the 8-slot module bus whose selects come from the 3-bit address decoder (one-hot select per address).
- Accepts one read/write request at a time from an upstream requester (valid/ready), drives the bus address and strobe, waits for the addressed module's ACK, and returns read data or a timeout error (valid/ready).
- Sits between the command source and the decoder/module array; each module gates its decoder select with BUS_STB.

Parameters:
DATA_W, 16, bus data width in bits.
TIMEOUT_CYC, 15, max cycles BUS_STB stays high awaiting ACK before an error response; legal range 1..255.

Ports:
CLK  in  1  single clock, all logic rising-edge.
RST_N  in  1  asynchronous, active-low reset.
REQ_VALID  in  1  request present.
REQ_READY  out  1  controller can accept a request.
REQ_ADDR  in  3  target module index 0..7.
REQ_WRITE  in  1  1 = write, 0 = read.
REQ_WDATA  in  DATA_W  write data.
RSP_VALID  out  1  response present.
RSP_READY  in  1  requester takes response.
RSP_RDATA  out  DATA_W  read data (0 for writes and errors).
RSP_ERR  out  1  1 = timeout, no ACK.
BUS_ADDR  out  3  to decoder ADDR input.
BUS_STB  out  1  access strobe, qualifies decoder select.
BUS_WE  out  1  write enable during strobe.
BUS_WDATA  out  DATA_W  write data to modules.
BUS_RDATA  in  DATA_W  read data from selected module, valid with ACK.
BUS_ACK  in  1  selected module completes access.

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs registered except REQ_READY (decoded from state).
- Reset values: state IDLE, REQ_READY 1, RSP_VALID 0, RSP_RDATA 0, RSP_ERR 0, BUS_ADDR 0, BUS_STB 0, BUS_WE 0, BUS_WDATA 0, timeout counter 0.
- States: IDLE, ACCESS, RESP.
- IDLE: REQ_READY=1. On REQ_VALID, capture ADDR/WRITE/WDATA into BUS_ADDR/BUS_WE/BUS_WDATA, set BUS_STB=1, clear counter, go to ACCESS. BUS_STB rises the cycle after acceptance.
- ACCESS: REQ_READY=0; BUS_ADDR, BUS_WE, BUS_WDATA held stable. Each cycle without BUS_ACK increments counter.
  - BUS_ACK=1: BUS_STB->0, BUS_WE->0, RSP_VALID->1, RSP_ERR->0, RSP_RDATA<=BUS_RDATA if read else 0; go to RESP. Minimum access: 1 strobe cycle.
  - Counter reaches TIMEOUT_CYC-1 with no ACK: BUS_STB->0, RSP_VALID->1, RSP_ERR->1, RSP_RDATA->0; go to RESP. BUS_STB high exactly TIMEOUT_CYC cycles.
  - ACK on the same cycle as timeout: ACK wins, RSP_ERR=0.
- RESP: RSP_VALID held with stable RDATA/ERR until RSP_READY=1 in same cycle; then RSP_VALID->0, go to IDLE. No new request accepted on that cycle (REQ_READY asserts next cycle). Throughput bound: one transaction per ≥3 cycles.
- BUS_ACK in IDLE or RESP ignored, no state change.
- BUS_ADDR keeps last value in IDLE/RESP (no glitching of decoder); BUS_STB low outside ACCESS.
- REQ_ADDR needs no range check (all 8 codes valid).
- Reset asserted mid-ACCESS or mid-RESP: BUS_STB and RSP_VALID drop immediately (asynchronously); in-flight transaction discarded, no response issued after reset release.

Decomposition:
- Shared package: state enumeration (IDLE/ACCESS/RESP), BUS_ADDR_W=3, NUM_MODULES=8, default DATA_W and TIMEOUT_CYC constants.
- One sub-module: bus_timeout_timer (clear, enable, TIMEOUT_CYC compare -> expired pulse; 8-bit counter).
- Decoder instantiated beside this block at top level, not inside it.

Test Plan:
- Write addr 3, data 0xA5A5; module ACKs on 2nd strobe cycle -> BUS_ADDR=3, BUS_WE=1, BUS_STB high 2 cycles, RSP_VALID with ERR=0, RDATA=0.
- Read addr 6; ACK on 1st strobe cycle with BUS_RDATA=0x1234 -> RSP_RDATA=0x1234, ERR=0; REQ_READY low from acceptance until cycle after RSP handshake.
- Read addr 0, no ACK, TIMEOUT_CYC=15 -> BUS_STB high exactly 15 cycles, RSP_ERR=1, RSP_RDATA=0; ACK arriving on cycle 15 instead -> ERR=0.
- RSP_READY held low 5 cycles -> RSP_VALID/RDATA/ERR stable throughout; second REQ_VALID held high not accepted until IDLE; back-to-back 8 requests addr 0..7 complete in order.
- Assert RST_N low mid-ACCESS -> BUS_STB and RSP_VALID 0 immediately, no spurious response after release; stray BUS_ACK in IDLE -> no RSP_VALID.

Source files
------------

// File: rtl/module_bus_controller_pkg.sv
// rtl/module_bus_controller_pkg.sv - shared constants and state type for the module bus controller
//
// Purpose : Constants and the controller state enumeration, imported by the
//           controller top and its timeout timer.
// Contents: BUS_ADDR_W, NUM_MODULES, DEF_DATA_W, DEF_TIMEOUT_CYC, TIMER_W,
//           bus_state_e (ST_IDLE / ST_ACCESS / ST_RESP).
package module_bus_controller_pkg;

    localparam int BUS_ADDR_W      = 3;
    localparam int NUM_MODULES     = 8;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 15;
    localparam int TIMER_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/module_bus_controller_bus_timeout_timer.sv
// rtl/module_bus_controller_bus_timeout_timer.sv - strobe timeout counter with expiry compare
//
// Purpose : Counts strobe cycles without ACK; flags expiry on the last allowed cycle.
// Ports   : i_clk, i_rst_n   clock, async active-low reset
//           i_clear          zero the counter (request accepted)
//           i_enable         count this cycle (strobe high, no ACK)
//           o_expired        combinational: enabled and counter at TIMEOUT_CYC-1
import module_bus_controller_pkg::*;

module bus_timeout_timer #(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] r_count;

    // Expiry is gated by enable, so an ACK (which drops enable) always wins
    // over a timeout landing on the same cycle.
    assign o_expired = i_enable && (r_count == LAST_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/module_bus_controller.sv
// rtl/module_bus_controller.sv - single-master transaction controller for the 8-slot module bus
//
// Purpose : Accepts one request at a time, strobes the addressed module, waits
//           for ACK or timeout, and returns read data or an error response.
// Ports   : i_clk, i_rst_n                                  clock, async active-low reset
//           i_req_valid/o_req_ready, i_req_addr/write/wdata request channel
//           o_rsp_valid/i_rsp_ready, o_rsp_rdata/err        response channel
//           o_bus_addr/stb/we/wdata, i_bus_rdata/ack        module bus (to decoder)
import module_bus_controller_pkg::*;

module module_bus_controller #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [BUS_ADDR_W-1:0] i_req_addr,
    input  logic                  i_req_write,
    input  logic [DATA_W-1:0]     i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [BUS_ADDR_W-1:0] o_bus_addr,
    output logic                  o_bus_stb,
    output logic                  o_bus_we,
    output logic [DATA_W-1:0]     o_bus_wdata,
    input  logic [DATA_W-1:0]     i_bus_rdata,
    input  logic                  i_bus_ack
);

    bus_state_e            r_state,     w_state_nxt;
    logic [BUS_ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
    logic                  r_bus_stb,   w_bus_stb_nxt;
    logic                  r_bus_we,    w_bus_we_nxt;
    logic [DATA_W-1:0]     r_bus_wdata, w_bus_wdata_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_err,   w_rsp_err_nxt;

    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;

    assign w_timer_en = (r_state == ST_ACCESS) && !i_bus_ack;

    bus_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_bus_addr  <= '0;
            r_bus_stb   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_stb   <= w_bus_stb_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_stb_nxt   = r_bus_stb;
        w_bus_we_nxt    = r_bus_we;
        w_bus_wdata_nxt = r_bus_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_timer_clear   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_bus_addr_nxt  = i_req_addr;
                    w_bus_we_nxt    = i_req_write;
                    w_bus_wdata_nxt = i_req_wdata;
                    w_bus_stb_nxt   = 1'b1;
                    w_timer_clear   = 1'b1;
                    w_state_nxt     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (i_bus_ack) begin
                    w_bus_stb_nxt   = 1'b0;
                    w_bus_we_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_bus_we ? '0 : i_bus_rdata;
                    w_state_nxt     = ST_RESP;
                end else if (w_expired) begin
                    w_bus_stb_nxt   = 1'b0;
                    w_bus_we_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Returning to IDLE here (not accepting) keeps REQ_READY low on
                // the handshake cycle, giving the 3-cycle minimum turnaround.
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bus_stb_nxt = 1'b0;
            end
        endcase
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_stb   = r_bus_stb;
    assign o_bus_we    = r_bus_we;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_module_bus_controller.sv
// tb/tb_module_bus_controller.sv - self-checking bench for module_bus_controller
module tb_module_bus_controller;

    localparam int DW = 16;
    localparam int T  = 15;
    localparam int NO_ACK = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_addr = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [2:0]    bus_addr;
    logic          bus_stb;
    logic          bus_we;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    module_bus_controller #(.DATA_W(DW), .TIMEOUT_CYC(T)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_write (req_write),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_bus_addr  (bus_addr),
        .o_bus_stb   (bus_stb),
        .o_bus_we    (bus_we),
        .o_bus_wdata (bus_wdata),
        .i_bus_rdata (bus_rdata),
        .i_bus_ack   (bus_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: ACK on strobe cycle k (0-based) ends the access after k+1
    // strobe cycles unless k >= T, in which case the strobe lasts T cycles and errors.
    function automatic void model(input logic wr, input int ack_at, input logic [DW-1:0] rd,
                                  output int stb_cyc, output logic err, output logic [DW-1:0] rdata);
        if (ack_at < T) begin
            stb_cyc = ack_at + 1;
            err     = 1'b0;
            rdata   = wr ? '0 : rd;
        end else begin
            stb_cyc = T;
            err     = 1'b1;
            rdata   = '0;
        end
    endfunction

    // Called at a negedge with the controller idle; returns at the negedge after the response handshake.
    task automatic run_txn(input logic wr, input logic [2:0] addr, input logic [DW-1:0] wdata,
                           input int ack_at, input logic [DW-1:0] rd, input int rdy_delay,
                           input logic keep_valid, input logic [2:0] next_addr,
                           input int exp_stb, input logic exp_err, input logic [DW-1:0] exp_rdata);
        int   cycles = 0;
        logic ready_low_ok = 1'b1;
        logic addr_ok = 1'b1;
        logic stable_ok = 1'b1;
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        if (keep_valid) begin
            req_addr  = next_addr;
            req_write = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
        chk("bus_stb_rise", {31'd0, bus_stb}, 32'd1);
        chk("bus_addr", {29'd0, bus_addr}, {29'd0, addr});
        chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
        chk("bus_wdata", {16'd0, bus_wdata}, {16'd0, wdata});
        while (bus_stb && cycles < 300) begin
            if (req_ready) ready_low_ok = 1'b0;
            if (bus_addr !== addr || bus_wdata !== wdata || bus_we !== wr) addr_ok = 1'b0;
            if (cycles == ack_at) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = DW'($urandom);
            end
            cycles++;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        chk("stb_cycles", cycles, exp_stb);
        chk("req_ready_low_access", {31'd0, ready_low_ok}, 32'd1);
        chk("bus_held_access", {31'd0, addr_ok}, 32'd1);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        chk("bus_we_after", {31'd0, bus_we}, 32'd0);
        for (int i = 0; i < rdy_delay; i++) begin
            bus_ack = 1'($urandom);
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_err === exp_err && rsp_rdata === exp_rdata &&
                  req_ready === 1'b0 && bus_stb === 1'b0 && bus_addr === addr))
                stable_ok = 1'b0;
        end
        bus_ack = 1'b0;
        chk("resp_stable", {31'd0, stable_ok}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("no_accept_on_handshake", {31'd0, bus_stb}, 32'd0);
    endtask

    typedef struct {
        logic          wr;
        logic [2:0]    addr;
        logic [DW-1:0] wdata;
        int            ack_at;
        logic [DW-1:0] rd;
        int            rdy_delay;
        int            exp_stb;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int            s;
        logic          e;
        logic [DW-1:0] r;

        vecs[0] = '{1'b1, 3'd3, 16'hA5A5, 1,      16'hDEAD, 0, 2,  1'b0, 16'h0000};
        vecs[1] = '{1'b0, 3'd6, 16'h0000, 0,      16'h1234, 0, 1,  1'b0, 16'h1234};
        vecs[2] = '{1'b0, 3'd0, 16'h0000, NO_ACK, 16'hFFFF, 0, 15, 1'b1, 16'h0000};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 14,     16'h5555, 0, 15, 1'b0, 16'h5555};
        vecs[4] = '{1'b0, 3'd2, 16'h0000, 3,      16'hBEEF, 5, 4,  1'b0, 16'hBEEF};
        vecs[5] = '{1'b1, 3'd5, 16'h0F0F, NO_ACK, 16'h7777, 2, 15, 1'b1, 16'h0000};
        vecs[6] = '{1'b1, 3'd7, 16'hFFFF, 15,     16'h1111, 1, 15, 1'b1, 16'h0000};

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_bus_addr", {29'd0, bus_addr}, 32'd0);
        chk("rst_bus_stb", {31'd0, bus_stb}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_wdata", {16'd0, bus_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at, vecs[i].rd,
                    vecs[i].rdy_delay, 1'b0, 3'd0,
                    vecs[i].exp_stb, vecs[i].exp_err, vecs[i].exp_rdata);

        // Back-to-back reads with REQ_VALID held high across transactions.
        for (int a = 0; a < 8; a++) begin
            model(1'b0, a % 3, 16'h1000 + 16'(a), s, e, r);
            run_txn(1'b0, 3'(a), 16'h0000, a % 3, 16'h1000 + 16'(a), a % 2,
                    (a < 7), 3'(a + 1), s, e, r);
        end
        req_valid = 1'b0;

        // Randomized transactions against the reference model.
        for (int n = 0; n < 24; n++) begin
            logic          wr;
            logic [2:0]    ad;
            logic [DW-1:0] wd, rd;
            int            aa, dly;
            wr  = 1'($urandom);
            ad  = 3'($urandom);
            wd  = DW'($urandom);
            rd  = DW'($urandom);
            aa  = $urandom_range(0, T + 3);
            dly = $urandom_range(0, 3);
            model(wr, aa, rd, s, e, r);
            run_txn(wr, ad, wd, aa, rd, dly, 1'b0, 3'd0, s, e, r);
        end

        // Reset mid-ACCESS: strobe drops asynchronously, no response afterwards.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_stb", {31'd0, bus_stb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_stb", {31'd0, bus_stb}, 32'd0);
        chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        bus_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic quiet = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b0 || bus_stb !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
            end
            chk("no_rsp_after_reset_stray_ack", {31'd0, quiet}, 32'd1);
        end
        bus_ack = 1'b0;

        // Reset mid-RESP: pending response dropped asynchronously.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd1;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ack = 1'b1; bus_rdata = 16'hCAFE;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rsp_valid_after_release", {31'd0, rsp_valid}, 32'd0);

        model(1'b0, 2, 16'h4242, s, e, r);
        run_txn(1'b0, 3'd2, 16'h0000, 2, 16'h4242, 1, 1'b0, 3'd0, s, e, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
